key_sw_event_irq: RTL

//  Board-input front end for the DE10-Nano PULPino system. It conditions the raw
//  KEY[3:1] push-buttons and SW[9:0] slide switches: 2-FF synchronisation,
//  per-bit debounce and edge detection. It latches key-press and switch-change

---
 rtl/key_sw_event_irq.sv | 127 ++++++++++++
 1 files changed

// File: rtl/key_sw_event_irq.sv
// Board-input front end: synchronises and debounces push-buttons and slide
// switches, turns debounced changes into sticky pending flags and drives one
// level interrupt. Keys occupy the low bits of every event vector, switches
// the bits above them.
//
// Clear interface: clr_valid_i is a single-cycle strobe with no ready/ack. On
// any rising edge where clr_valid_i=1, every pending bit selected by
// clr_mask_i is cleared, unless an event on that bit lands in the same cycle,
// in which case the bit stays set. clr_mask_i is ignored while clr_valid_i=0.
module key_sw_event_irq #(
  parameter int NUM_KEYS        = 3,
  parameter int NUM_SW          = 10,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_KEYS-1:0]          key_n_i,
  input  logic [NUM_SW-1:0]            sw_i,
  output logic [NUM_KEYS-1:0]          key_o,
  output logic [NUM_SW-1:0]            sw_o,
  input  logic [NUM_KEYS+NUM_SW-1:0]   irq_en_i,
  input  logic                         clr_valid_i,
  input  logic [NUM_KEYS+NUM_SW-1:0]   clr_mask_i,
  output logic [NUM_KEYS+NUM_SW-1:0]   pending_o,
  output logic                         irq_o
);

  localparam int N     = NUM_KEYS + NUM_SW;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  // Raw buttons idle high, so their synchroniser flops reset to "released".
  localparam logic [N-1:0]     SYNC_RST = {{NUM_SW{1'b0}}, {NUM_KEYS{1'b1}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N-1:0]     raw;
  logic [N-1:0]     sync1_q;
  logic [N-1:0]     sync2_q;
  logic [N-1:0]     cond;
  logic [N-1:0]     stable_q;
  logic [N-1:0]     stable_d;
  logic [N-1:0]     prev_q;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic [N-1:0]     evt;
  logic [N-1:0]     clr_vec;
  logic [N-1:0]     pending_q;
  logic [N-1:0]     pending_d;
  logic             irq_q;
  logic             irq_d;

  assign raw = {sw_i, key_n_i};

  // Two-flop synchroniser on every raw input bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= SYNC_RST;
      sync2_q <= SYNC_RST;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Internal sense is 1 = active for both keys (inverted) and switches.
  assign cond = {sync2_q[N-1:NUM_KEYS], ~sync2_q[NUM_KEYS-1:0]};

  // Per-bit debounce: accept a new level only after it has differed from the
  // stable value for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (cond[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = cond[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounce state: stable levels, their one-cycle history and the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= '0;
      prev_q   <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      prev_q   <= stable_q;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Keys report presses only; switches report any change of level.
  assign evt = {stable_q[N-1:NUM_KEYS] ^ prev_q[N-1:NUM_KEYS],
                stable_q[NUM_KEYS-1:0] & ~prev_q[NUM_KEYS-1:0]};

  // Pending next state: clear first, then OR in events so an event wins a race.
  always_comb begin
    clr_vec   = clr_mask_i & {N{clr_valid_i}};
    pending_d = (pending_q & ~clr_vec) | evt;
    irq_d     = |(pending_q & irq_en_i);
  end

  // Sticky pending flags and the registered interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      irq_q     <= irq_d;
    end
  end

  assign key_o     = stable_q[NUM_KEYS-1:0];
  assign sw_o      = stable_q[N-1:NUM_KEYS];
  assign pending_o = pending_q;
  assign irq_o     = irq_q;

endmodule
